// File: rtl/param_reg_bank_pkg.sv
// Shared types and the per-register next-state arithmetic for the parametrised register bank.
package param_reg_bank_pkg;

    localparam int MAX_W = 32;

    localparam logic [1:0] FS_CLEAR = 2'b00;
    localparam logic [1:0] FS_LOAD  = 2'b01;
    localparam logic [1:0] FS_INC   = 2'b10;
    localparam logic [1:0] FS_DEC   = 2'b11;

    typedef struct packed {
        logic [MAX_W-1:0] val;
        logic             carry;
        logic             borrow;
    } next_t;

    // Values are carried at MAX_W bits; only the low 'width' bits are meaningful.
    function automatic next_t next_val(
        input logic [MAX_W-1:0] cur,
        input logic [1:0]       fs,
        input logic [MAX_W-1:0] din,
        input logic             sat,
        input int unsigned      width
    );
        next_t            res;
        logic [MAX_W-1:0] top;
        top        = (width >= 32'd32) ? {MAX_W{1'b1}} : ((32'd1 << width) - 32'd1);
        res.val    = cur;
        res.carry  = 1'b0;
        res.borrow = 1'b0;
        case (fs)
            FS_CLEAR: res.val = {MAX_W{1'b0}};
            FS_LOAD:  res.val = din & top;
            FS_INC: begin
                if (cur == top) begin
                    res.carry = 1'b1;
                    res.val   = sat ? top : {MAX_W{1'b0}};
                end else begin
                    res.val = cur + 32'd1;
                end
            end
            FS_DEC: begin
                if (cur == {MAX_W{1'b0}}) begin
                    res.borrow = 1'b1;
                    res.val    = sat ? {MAX_W{1'b0}} : top;
                end else begin
                    res.val = cur - 32'd1;
                end
            end
            default: res.val = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/param_reg_bank_if.sv
// Control/data bus of the register bank; the master drives selects and data, the slave returns reads and flags.
interface param_reg_bank_if
    import param_reg_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS)
);

    logic [1:0]          FunSel;
    logic [NUM_REGS-1:0] RegSel;
    logic [WIDTH-1:0]    DataIn;
    logic [SEL_W-1:0]    OutASel;
    logic [SEL_W-1:0]    OutBSel;
    logic                FlagClr;
    logic [WIDTH-1:0]    OutA;
    logic [WIDTH-1:0]    OutB;
    logic [NUM_REGS-1:0] CarryFlags;
    logic [NUM_REGS-1:0] BorrowFlags;
    logic [NUM_REGS-1:0] ZeroFlags;

    modport master (
        output FunSel, RegSel, DataIn, OutASel, OutBSel, FlagClr,
        input  OutA, OutB, CarryFlags, BorrowFlags, ZeroFlags
    );

    modport slave (
        input  FunSel, RegSel, DataIn, OutASel, OutBSel, FlagClr,
        output OutA, OutB, CarryFlags, BorrowFlags, ZeroFlags
    );

endinterface

// File: rtl/param_reg_bank_reg_cell.sv
// One bank register with its sticky carry/borrow flags; exposes its next state for read bypass.
module reg_cell
    import param_reg_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             we,
    input  logic [1:0]       fun_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] val_next,
    output logic             carry,
    output logic             borrow
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    logic             carry_q;
    logic             carry_d;
    logic             borrow_q;
    logic             borrow_d;
    logic [MAX_W-1:0] cur_ext_s;
    logic [MAX_W-1:0] din_ext_s;
    next_t            nv_s;
    logic             unused_nv_s;

    // Widen to the package arithmetic width and evaluate the selected function.
    always_comb begin
        cur_ext_s              = {MAX_W{1'b0}};
        din_ext_s              = {MAX_W{1'b0}};
        cur_ext_s[WIDTH-1:0]   = val_q;
        din_ext_s[WIDTH-1:0]   = data_in;
        nv_s                   = next_val(cur_ext_s, fun_sel, din_ext_s, SATURATE, WIDTH);
        unused_nv_s            = ^nv_s.val;
    end

    // Next state: reset dominates; a new overflow event beats a same-cycle flag clear.
    always_comb begin
        val_d    = val_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        if (!Reset) begin
            val_d    = {WIDTH{1'b0}};
            carry_d  = 1'b0;
            borrow_d = 1'b0;
        end else begin
            if (we) begin
                val_d = nv_s.val[WIDTH-1:0];
            end else begin
                val_d = val_q;
            end
            carry_d  = (we & nv_s.carry)  | (carry_q  & ~flag_clr);
            borrow_d = (we & nv_s.borrow) | (borrow_q & ~flag_clr);
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        val_q    <= val_d;
        carry_q  <= carry_d;
        borrow_q <= borrow_d;
    end

    assign val      = val_q;
    assign val_next = val_d;
    assign carry    = carry_q;
    assign borrow   = borrow_q;

endmodule

// File: rtl/param_reg_bank.sv
// Parametrised register bank feeding the ALU A/B inputs: NUM_REGS cells, two read ports, optional bypass.
module param_reg_bank
    import param_reg_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int SATURATE = 0,
    parameter int BYPASS   = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    param_reg_bank_if.slave  bus
);

    logic [WIDTH-1:0]    cur_s [NUM_REGS];
    logic [WIDTH-1:0]    nxt_s [NUM_REGS];
    logic [NUM_REGS-1:0] carry_s;
    logic [NUM_REGS-1:0] borrow_s;
    logic [NUM_REGS-1:0] zero_s;
    logic [WIDTH-1:0]    out_a_s;
    logic [WIDTH-1:0]    out_b_s;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
        reg_cell #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE != 0)
        ) u_cell (
            .Clock    (Clock),
            .Reset    (Reset),
            .we       (bus.RegSel[gi]),
            .fun_sel  (bus.FunSel),
            .data_in  (bus.DataIn),
            .flag_clr (bus.FlagClr),
            .val      (cur_s[gi]),
            .val_next (nxt_s[gi]),
            .carry    (carry_s[gi]),
            .borrow   (borrow_s[gi])
        );
    end

    // Read port A; out-of-range selects read as zero, bypass shows the value being written.
    always_comb begin
        out_a_s = {WIDTH{1'b0}};
        if (32'(bus.OutASel) < NUM_REGS) begin
            if ((BYPASS != 0) && bus.RegSel[bus.OutASel]) begin
                out_a_s = nxt_s[bus.OutASel];
            end else begin
                out_a_s = cur_s[bus.OutASel];
            end
        end else begin
            out_a_s = {WIDTH{1'b0}};
        end
    end

    // Read port B, identical policy to port A.
    always_comb begin
        out_b_s = {WIDTH{1'b0}};
        if (32'(bus.OutBSel) < NUM_REGS) begin
            if ((BYPASS != 0) && bus.RegSel[bus.OutBSel]) begin
                out_b_s = nxt_s[bus.OutBSel];
            end else begin
                out_b_s = cur_s[bus.OutBSel];
            end
        end else begin
            out_b_s = {WIDTH{1'b0}};
        end
    end

    // Zero flags always reflect stored contents, never the bypassed value.
    always_comb begin
        zero_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            zero_s[i] = (cur_s[i] == {WIDTH{1'b0}});
        end
    end

    assign bus.OutA        = out_a_s;
    assign bus.OutB        = out_b_s;
    assign bus.CarryFlags  = carry_s;
    assign bus.BorrowFlags = borrow_s;
    assign bus.ZeroFlags   = zero_s;

endmodule

// File: tb/tb_param_reg_bank.sv
// Bench for param_reg_bank: a wrap/no-bypass and a saturate/bypass instance share stimulus and a reference model.
module tb_param_reg_bank;
    import param_reg_bank_pkg::*;

    localparam int          W    = 8;
    localparam int          N    = 8;
    localparam int          SW   = 3;
    localparam int unsigned MAXV = 255;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] fs;
    logic [7:0] rs;
    logic [7:0] din;
    logic [2:0] asel;
    logic [2:0] bsel;
    logic       fclr;

    always #5 Clock = ~Clock;

    param_reg_bank_if #(.WIDTH(W), .NUM_REGS(N), .SEL_W(SW)) ifw ();
    param_reg_bank_if #(.WIDTH(W), .NUM_REGS(N), .SEL_W(SW)) ifs ();

    assign ifw.FunSel  = fs;   assign ifs.FunSel  = fs;
    assign ifw.RegSel  = rs;   assign ifs.RegSel  = rs;
    assign ifw.DataIn  = din;  assign ifs.DataIn  = din;
    assign ifw.OutASel = asel; assign ifs.OutASel = asel;
    assign ifw.OutBSel = bsel; assign ifs.OutBSel = bsel;
    assign ifw.FlagClr = fclr; assign ifs.FlagClr = fclr;

    param_reg_bank #(.WIDTH(W), .NUM_REGS(N), .SEL_W(SW), .SATURATE(0), .BYPASS(0))
        u_wrap (.Clock(Clock), .Reset(Reset), .bus(ifw));
    param_reg_bank #(.WIDTH(W), .NUM_REGS(N), .SEL_W(SW), .SATURATE(1), .BYPASS(1))
        u_sat  (.Clock(Clock), .Reset(Reset), .bus(ifs));

    // Reference model: index 0 = wrap/no bypass, index 1 = saturate/bypass.
    int unsigned mreg [2][N];
    bit          mcar [2][N];
    bit          mbor [2][N];
    bit          mvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned mnext(input int c, input int i);
        int unsigned v;
        v = mreg[c][i];
        if (Reset == 1'b0) return 0;
        if (!rs[i]) return v;
        case (fs)
            2'b00:   return 0;
            2'b01:   return int'(din);
            2'b10:   return (v == MAXV) ? ((c == 1) ? MAXV : 0) : v + 1;
            default: return (v == 0) ? ((c == 1) ? 0 : MAXV) : v - 1;
        endcase
    endfunction

    function automatic int unsigned mread(input int c, input logic [2:0] sel);
        if (c == 1 && rs[sel]) return mnext(c, int'(sel));
        return mreg[c][sel];
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) begin
                bit ev_c;
                bit ev_b;
                ev_c = (rs[i] == 1'b1) && (fs == 2'b10) && (mreg[c][i] == MAXV);
                ev_b = (rs[i] == 1'b1) && (fs == 2'b11) && (mreg[c][i] == 0);
                if (Reset == 1'b0) begin
                    mcar[c][i] = 1'b0;
                    mbor[c][i] = 1'b0;
                end else begin
                    mcar[c][i] = ev_c || (mcar[c][i] && !fclr);
                    mbor[c][i] = ev_b || (mbor[c][i] && !fclr);
                end
                mreg[c][i] = mnext(c, i);
            end
        end
        if (Reset == 1'b0) mvalid = 1'b1;
    endtask

    task automatic check_all();
        logic [7:0] ez;
        logic [7:0] ec;
        logic [7:0] eb;
        if (!mvalid) return;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) begin
                ez[i] = (mreg[c][i] == 0);
                ec[i] = mcar[c][i];
                eb[i] = mbor[c][i];
            end
            if (c == 0) begin
                chk("wrap.OutA", ifw.OutA, mread(0, asel));
                chk("wrap.OutB", ifw.OutB, mread(0, bsel));
                chk("wrap.Zero", ifw.ZeroFlags, ez);
                chk("wrap.Carry", ifw.CarryFlags, ec);
                chk("wrap.Borrow", ifw.BorrowFlags, eb);
            end else begin
                chk("sat.OutA", ifs.OutA, mread(1, asel));
                chk("sat.OutB", ifs.OutB, mread(1, bsel));
                chk("sat.Zero", ifs.ZeroFlags, ez);
                chk("sat.Carry", ifs.CarryFlags, ec);
                chk("sat.Borrow", ifs.BorrowFlags, eb);
            end
        end
    endtask

    task automatic set_in(input logic r, input logic [1:0] f, input logic [7:0] s,
                          input logic [7:0] d, input logic [2:0] a, input logic [2:0] b,
                          input logic c);
        Reset = r; fs = f; rs = s; din = d; asel = a; bsel = b; fclr = c;
        #2;
        check_all();
    endtask

    task automatic edge_go();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    typedef struct {
        logic       rstn;
        logic [1:0] f;
        logic [7:0] s;
        logic [7:0] d;
        logic [2:0] a;
        logic [2:0] b;
        logic       c;
        bit         en;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ecar;
        logic [7:0] ebor;
        logic [7:0] ezero;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values are for the wrap/no-bypass instance, sampled before each row's edge.
        tbl[0] = '{1'b0, 2'b01, 8'hFF, 8'hAA, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 2'b01, 8'h05, 8'd18, 3'd0, 3'd2, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        tbl[2] = '{1'b1, 2'b01, 8'h08, 8'hFF, 3'd0, 3'd2, 1'b0, 1'b1, 8'd18, 8'd18, 8'h00, 8'h00, 8'hFA};
        tbl[3] = '{1'b1, 2'b10, 8'h08, 8'h00, 3'd3, 3'd1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hF2};
        tbl[4] = '{1'b1, 2'b11, 8'h10, 8'h00, 3'd3, 3'd4, 1'b0, 1'b1, 8'h00, 8'h00, 8'h08, 8'h00, 8'hFA};
        tbl[5] = '{1'b1, 2'b00, 8'h00, 8'h00, 3'd4, 3'd3, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h08, 8'h10, 8'hEA};
        tbl[6] = '{1'b1, 2'b00, 8'h00, 8'h00, 3'd4, 3'd3, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h08, 8'h10, 8'hEA};
        tbl[7] = '{1'b1, 2'b11, 8'h10, 8'h00, 3'd4, 3'd0, 1'b0, 1'b1, 8'hFF, 8'd18, 8'h00, 8'h00, 8'hEA};
        tbl[8] = '{1'b1, 2'b00, 8'h05, 8'h00, 3'd4, 3'd2, 1'b0, 1'b1, 8'hFE, 8'd18, 8'h00, 8'h00, 8'hEA};
        tbl[9] = '{1'b1, 2'b00, 8'h00, 8'h00, 3'd0, 3'd2, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF};

        for (int k = 0; k < 10; k++) begin
            set_in(tbl[k].rstn, tbl[k].f, tbl[k].s, tbl[k].d, tbl[k].a, tbl[k].b, tbl[k].c);
            if (tbl[k].en) begin
                chk($sformatf("tbl%0d.OutA", k), ifw.OutA, tbl[k].ea);
                chk($sformatf("tbl%0d.OutB", k), ifw.OutB, tbl[k].eb);
                chk($sformatf("tbl%0d.Carry", k), ifw.CarryFlags, tbl[k].ecar);
                chk($sformatf("tbl%0d.Borrow", k), ifw.BorrowFlags, tbl[k].ebor);
                chk($sformatf("tbl%0d.Zero", k), ifw.ZeroFlags, tbl[k].ezero);
            end
            edge_go();
        end

        // Saturation at all-ones, sticky carry, clear, and clear racing a new event.
        set_in(1'b1, FS_LOAD, 8'h08, 8'hFF, 3'd3, 3'd3, 1'b0); edge_go();
        repeat (3) begin
            set_in(1'b1, FS_INC, 8'h08, 8'h00, 3'd3, 3'd3, 1'b0); edge_go();
        end
        set_in(1'b1, FS_CLEAR, 8'h00, 8'h00, 3'd3, 3'd3, 1'b0);
        chk("sat.hold_ff", ifs.OutA, 32'hFF);
        chk("sat.carry3_set", ifs.CarryFlags[3], 32'd1);
        edge_go();
        set_in(1'b1, FS_CLEAR, 8'h00, 8'h00, 3'd3, 3'd3, 1'b1); edge_go();
        set_in(1'b1, FS_CLEAR, 8'h00, 8'h00, 3'd3, 3'd3, 1'b0);
        chk("sat.carry3_cleared", ifs.CarryFlags[3], 32'd0);
        edge_go();
        set_in(1'b1, FS_INC, 8'h08, 8'h00, 3'd3, 3'd3, 1'b1); edge_go();
        set_in(1'b1, FS_CLEAR, 8'h00, 8'h00, 3'd3, 3'd3, 1'b0);
        chk("sat.event_beats_clr", ifs.CarryFlags[3], 32'd1);
        chk("wrap.no_event_cleared", ifw.CarryFlags[3], 32'd0);
        edge_go();

        // Bypass versus registered read of a register being loaded.
        set_in(1'b1, FS_LOAD, 8'h20, 8'd7, 3'd5, 3'd5, 1'b0); edge_go();
        set_in(1'b1, FS_LOAD, 8'h20, 8'd25, 3'd5, 3'd0, 1'b0);
        chk("byp.same_cycle", ifs.OutA, 32'd25);
        chk("nobyp.old_value", ifw.OutA, 32'd7);
        edge_go();
        set_in(1'b1, FS_CLEAR, 8'h00, 8'h00, 3'd5, 3'd5, 1'b0);
        chk("nobyp.after_edge", ifw.OutA, 32'd25);
        edge_go();

        // Reset in the middle of counting.
        set_in(1'b1, FS_CLEAR, 8'hFF, 8'h00, 3'd0, 3'd0, 1'b0); edge_go();
        repeat (5) begin
            set_in(1'b1, FS_INC, 8'h01, 8'h00, 3'd0, 3'd0, 1'b0); edge_go();
        end
        set_in(1'b0, FS_INC, 8'h01, 8'h00, 3'd0, 3'd0, 1'b0);
        chk("rst.count5", ifw.OutA, 32'd5);
        edge_go();
        set_in(1'b1, FS_INC, 8'h01, 8'h00, 3'd0, 3'd0, 1'b0);
        chk("rst.zeroed", ifw.OutA, 32'd0);
        chk("rst.zeroflags", ifw.ZeroFlags, 32'hFF);
        edge_go();
        set_in(1'b1, FS_INC, 8'h01, 8'h00, 3'd0, 3'd0, 1'b0);
        chk("rst.resume1", ifw.OutA, 32'd1);
        edge_go();

        // Randomised traffic, biased toward the wrap boundaries.
        repeat (400) begin
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       d = 8'hFF;
                1:       d = 8'h00;
                2:       d = 8'hFE;
                default: d = 8'($urandom);
            endcase
            set_in(($urandom_range(0, 39) != 0), 2'($urandom), 8'($urandom), d,
                   3'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0));
            edge_go();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_reg_bank.md
Name: param_reg_bank

Overview:
Parametrised general-purpose register bank, the next generation of the fixed 4-register file. NUM_REGS registers of WIDTH bits each, with a multi-hot write-select mask and a 2-bit function select (clear/load/inc/dec). Adds a selectable wrap or saturate mode, sticky per-register carry/borrow flags, and optional write-to-read bypass. Sits between MuxA and the ALU A/B inputs in the CPU datapath.

Parameters:
- WIDTH, 8, register width in bits (2..32).
- NUM_REGS, 8, number of registers (2..16).
- SEL_W, $clog2(NUM_REGS), read-select width (derived; do not override).
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = clamp at all-ones / zero.
- BYPASS, 0, 1 = a read of a register being written this cycle returns the next-state value.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low; clock Clock.
- FunSel  in  2  00 clear, 01 load, 10 increment, 11 decrement.
- RegSel  in  NUM_REGS  multi-hot write enable, bit i selects register i.
- DataIn  in  WIDTH  load data.
- OutASel  in  SEL_W  read port A select.
- OutBSel  in  SEL_W  read port B select.
- FlagClr  in  1  clears all sticky flags.
- OutA  out  WIDTH  read port A.
- OutB  out  WIDTH  read port B.
- CarryFlags  out  NUM_REGS  sticky: register i overflowed (inc at all-ones).
- BorrowFlags  out  NUM_REGS  sticky: register i underflowed (dec at zero).
- ZeroFlags  out  NUM_REGS  combinational: register i == 0.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - All registers and sticky flags go to 0 and ZeroFlags goes all-ones.
  - Reset overrides RegSel, FunSel and FlagClr in that cycle.
- Write:
  - On each rising edge, every register i with RegSel[i]==1 applies FunSel.
  - Registers with RegSel[i]==0 hold their value.
  - Latency is 1 cycle; any number of registers can update at once.
- Functions:
  - Clear: writes 0.
  - Load: writes DataIn.
  - Inc: writes reg+1.
  - Dec: writes reg-1.
  - Arithmetic is unsigned, WIDTH bits.
- Wrap mode (SATURATE=0):
  - Inc at 2^WIDTH-1 gives 0 and sets CarryFlags[i].
  - Dec at 0 gives 2^WIDTH-1 and sets BorrowFlags[i].
- Saturate mode (SATURATE=1):
  - Inc at all-ones holds all-ones and sets CarryFlags[i].
  - Dec at 0 holds 0 and sets BorrowFlags[i].
- Sticky flags:
  - Once set, a flag stays set until FlagClr or Reset.
  - If FlagClr and a new overflow event occur in the same cycle, the new event wins and the flag ends the cycle set.
  - Clear and Load never set flags.
- Reads:
  - OutA = reg[OutASel] and OutB = reg[OutBSel], combinational.
  - Both ports may select the same register.
  - A select value >= NUM_REGS returns 0.
- Bypass:
  - With BYPASS=1, if the selected register has RegSel set this cycle, the read port shows the computed next value.
  - With BYPASS=0, reads always show the current (pre-edge) value.
- ZeroFlags are combinational from current register contents and do not depend on BYPASS.
- No X is allowed on any output after the first reset edge.

Decomposition:
- Package param_reg_bank_pkg holds:
  - FunSel encodings FS_CLEAR=2'b00, FS_LOAD=2'b01, FS_INC=2'b10, FS_DEC=2'b11;
  - function next_val(cur, fs, din, sat), returning the next value plus carry and borrow bits.
- Sub-module reg_cell: one WIDTH register plus its two sticky flags, instantiated NUM_REGS times by generate.
- The read muxes and bypass logic live in the top level.

Test Plan:
1. Reset=0 for one edge with RegSel=all-ones, FunSel=01, DataIn=8'hAA -> all registers 0, ZeroFlags=8'hFF, flags 0.
2. Load: RegSel=8'b0000_0101, FunSel=01, DataIn=8'd18, then OutASel=0, OutBSel=2 -> OutA=OutB=18 one cycle later; reg1 stays 0.
3. Wrap (SATURATE=0): load reg3=8'hFF, then inc -> reg3=0, CarryFlags[3]=1. Dec reg4 from 0 -> 8'hFF, BorrowFlags[4]=1.
4. Saturate (SATURATE=1): inc reg3 at 8'hFF three times -> stays 8'hFF, CarryFlags[3]=1. FlagClr=1 with no event -> flag 0. FlagClr together with another overflow -> flag stays 1.
5. Bypass:
   - BYPASS=1: OutASel=5 while RegSel[5]=1, FunSel=01, DataIn=8'd25 -> OutA=25 in the same cycle.
   - BYPASS=0: same stimulus -> OutA shows the old value until the edge.
6. Reset mid-operation: hold inc on reg0 for 5 cycles (reg0=5), assert Reset=0 for one edge -> reg0=0, and counting resumes from 0 after Reset=1.
